// File: rtl/cpu_defs.sv
// Shared definitions for the fetch front end: queue sizing default, fetch FSM
// state encodings, opcode constants and instruction field positions.
package cpu_defs;

  localparam int DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    DROP     = 2'd2
  } fetch_state_t;

  localparam logic [6:0] bneOp = 7'b1100011;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int FLAG_BIT   = 30;

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of the PC-control, instruction-memory and decode-side signals of the fetch queue.
// The queue connects through the slave modport; its environment uses master.
interface fetch_queue_if #(
  parameter int WIDTH = 32
);

  logic [WIDTH-1:0] fetchPc;
  logic             fetchValid;
  logic             fetchReady;
  logic             flush;
  logic             memReq;
  logic [WIDTH-1:0] memAddr;
  logic             memAck;
  logic [WIDTH-1:0] memData;
  logic             decodeValid;
  logic             decodeReady;
  logic [WIDTH-1:0] instruction;
  logic [WIDTH-1:0] instrPc;
  logic [6:0]       operatorType;
  logic [2:0]       operatorSubType;
  logic             operatorFlag;

  modport master (
    output fetchPc, fetchValid, flush, memAck, memData, decodeReady,
    input  fetchReady, memReq, memAddr, decodeValid, instruction, instrPc,
           operatorType, operatorSubType, operatorFlag
  );

  modport slave (
    input  fetchPc, fetchValid, flush, memAck, memData, decodeReady,
    output fetchReady, memReq, memAddr, decodeValid, instruction, instrPc,
           operatorType, operatorSubType, operatorFlag
  );

endinterface

// File: rtl/instr_queue.sv
// Circular buffer of {instruction, pc} entries with push, pop and clear.
// Head data is read combinationally; pointers wrap modulo DEPTH.
module instr_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_instr,
  input  logic [WIDTH-1:0]           push_pc,
  input  logic                       pop,
  input  logic                       clear,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head_instr,
  output logic [WIDTH-1:0]           head_pc
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] instr_mem [DEPTH];
   logic [WIDTH-1:0] pc_mem    [DEPTH];
   logic [AW-1:0]    head_ptr;
   logic [AW-1:0]    tail_ptr;
   logic [CW-1:0]    count_q;

   // NOTE: entries are reset here because the reset state is defined as all-zero
   // storage; a plain RAM without reset would be cheaper but leave X on the head.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            instr_mem[i] <= '0;
            pc_mem[i]    <= '0;
         end
      end else if (clear) begin
         // A flush voids any push or pop of the same cycle.
         head_ptr <= '0;
         tail_ptr <= '0;
         count_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         if (push) begin
            instr_mem[tail_ptr] <= push_instr;
            pc_mem[tail_ptr]    <= push_pc;
            tail_ptr            <= tail_ptr + AW'(1);
         end
         if (pop) begin
            head_ptr <= head_ptr + AW'(1);
         end
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   assign count      = count_q;
   assign head_instr = instr_mem[head_ptr];
   assign head_pc    = pc_mem[head_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: single-outstanding memory request FSM feeding an
// instruction queue, with flush handling that drops in-flight responses.
module fetch_queue
  import cpu_defs::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int WIDTH = 32
) (
  input  logic          clock,
  input  logic          reset,
  fetch_queue_if.slave  bus
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t     state;
   fetch_state_t     state_next;
   logic             mem_req_q;
   logic             req_next;
   logic [WIDTH-1:0] mem_addr_q;
   logic [WIDTH-1:0] addr_next;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] head_instr;
   logic [WIDTH-1:0] head_pc;
   logic             fetch_ready;
   logic             decode_valid;
   logic             accept;
   logic             push;
   logic             pop;

   // Accepting only while count<DEPTH reserves a slot for the eventual response.
   assign fetch_ready  = (state == IDLE) && (count < CW'(DEPTH)) && !bus.flush;
   assign accept       = bus.fetchValid && fetch_ready;
   assign decode_valid = (count != '0);
   assign pop          = decode_valid && bus.decodeReady;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         state      <= state_next;
         mem_req_q  <= req_next;
         mem_addr_q <= addr_next;
      end
   end

   // NOTE: every output of this block is defaulted first so no path infers a latch.
   always_comb begin
      state_next = state;
      req_next   = mem_req_q;
      addr_next  = mem_addr_q;
      push       = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               addr_next  = bus.fetchPc;
               req_next   = 1'b1;
               state_next = WAIT_MEM;
            end
         end
         WAIT_MEM: begin
            if (bus.memAck) begin
               push       = !bus.flush;
               req_next   = 1'b0;
               state_next = IDLE;
            end else if (bus.flush) begin
               state_next = DROP;
            end
         end
         DROP: begin
            if (bus.memAck) begin
               req_next   = 1'b0;
               state_next = IDLE;
            end
         end
         default: begin
            req_next   = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

   instr_queue #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_queue (
      .clock      (clock),
      .reset      (reset),
      .push       (push),
      .push_instr (bus.memData),
      .push_pc    (mem_addr_q),
      .pop        (pop),
      .clear      (bus.flush),
      .count      (count),
      .head_instr (head_instr),
      .head_pc    (head_pc)
   );

   assign bus.fetchReady      = fetch_ready;
   assign bus.memReq          = mem_req_q;
   assign bus.memAddr         = mem_addr_q;
   assign bus.decodeValid     = decode_valid;
   assign bus.instruction     = head_instr;
   assign bus.instrPc         = head_pc;
   assign bus.operatorType    = head_instr[OPCODE_MSB:OPCODE_LSB];
   assign bus.operatorSubType = head_instr[FUNCT3_MSB:FUNCT3_LSB];
   assign bus.operatorFlag    = head_instr[FLAG_BIT];

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4: instruction queue entries; power of two, at least 2.
REQ-002 Parameter WIDTH, default 32: instruction and address width.
REQ-003 clock  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 fetchPc  in  32  word address of the next instruction, from PC control.
REQ-006 fetchValid  in  1  fetchPc is a new fetch request this cycle.
REQ-007 fetchReady  out  1  request accepted this cycle when high together with fetchValid.
REQ-008 flush  in  1  redirect (pcChange or taken branch); discard all fetched and in-flight work.
REQ-009 memReq  out  1  instruction memory read request.
REQ-010 memAddr  out  32  read address; stable while memReq is high.
REQ-011 memAck  in  1  memData valid; completes the outstanding request.
REQ-012 memData  in  32  returned instruction word.
REQ-013 decodeValid  out  1  queue head is valid.
REQ-014 decodeReady  in  1  decoder consumes the head this cycle.
REQ-015 instruction  out  32  head instruction word.
REQ-016 instrPc  out  32  fetch address of the head instruction.
REQ-017 operatorType  out  7  instruction[6:0].
REQ-018 operatorSubType  out  3  instruction[14:12].
REQ-019 operatorFlag  out  1  instruction[30].

Function
REQ-020 States: IDLE, WAIT_MEM, DROP; at most one memory request outstanding.
REQ-021 fetchReady = (state==IDLE) & (count<DEPTH) & !flush; combinational.
REQ-022 Acceptance (fetchValid&fetchReady): memAddr <= fetchPc, memReq <= 1, state <= WAIT_MEM; memReq rises the next cycle.
REQ-023 WAIT_MEM with memAck and no flush: push {memData, memAddr} to the tail, memReq <= 0, state <= IDLE; the entry is visible at the head no earlier than the next cycle.
REQ-024 Space for the response is reserved at acceptance (count<DEPTH); the queue never overflows, and a push never stalls.
REQ-025 Pop when decodeValid&decodeReady; simultaneous push and pop leaves count unchanged.
REQ-026 decodeValid = (count!=0); head outputs are combinational from the head entry; operatorType, operatorSubType and operatorFlag are slices of instruction.
REQ-027 flush: count, head and tail pointers become 0 next cycle; a pop and a push in the same cycle are void.
REQ-028 flush in WAIT_MEM without memAck: state <= DROP; memReq and memAddr are held.
REQ-029 flush with memAck in the same cycle: the response is discarded, memReq <= 0, state <= IDLE.
REQ-030 DROP: the response is discarded on memAck, memReq <= 0, state <= IDLE; a flush in DROP keeps DROP.
REQ-031 fetchValid while fetchReady is low is ignored; PC control re-presents the request.
REQ-032 Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits wide.

Reset
REQ-033 reset: state=IDLE, count=0, pointers=0, memReq=0, memAddr=0, decodeValid=0, all queue entries zeroed.
REQ-034 reset mid-request drops the outstanding request; memReq falls asynchronously.

Structure
REQ-035 Shared package cpu_defs: DEPTH default, state encodings, opcode constants (bneOp=7'b1100011), field bit positions.
REQ-036 Sub-module instr_queue: circular buffer with push, pop, clear, count, and head data; fetch_queue holds the FSM and memory handshake.

Verification
REQ-037 Basic fetch: fetchPc=0x10 accepted, memAck 3 cycles later with memData=0x00B50463 -> decodeValid=1, instrPc=0x10, operatorType=7'b1100011, operatorSubType=3'b000, operatorFlag=0.
REQ-038 Full queue: 4 fetches, decodeReady=0 -> count=4, fetchReady=0; one pop -> fetchReady=1 the next cycle.
REQ-039 Flush in WAIT_MEM: flush at accept+1, memAck at accept+4 with 0xDEADBEEF -> state DROP, word never visible, decodeValid=0, fetchReady=1 after the ack.
REQ-040 Flush coincident with memAck and pop, count=2 -> count=0, state=IDLE, no entry pushed.
REQ-041 Wrap: 10 fetches with continuous pop, PCs 0..9 -> instrPc sequence 0..9 in order, no loss or duplicate.
REQ-042 Reset asserted in WAIT_MEM -> memReq=0 immediately, count=0, and a late memAck is ignored.
